// File: rtl/matrix_mult_driver.sv
// matrix_mult_driver: streams A then B into packed operand buses, pulses o_calc, waits for the multiplier's ready to rise (or times out), then streams the result out.
module matrix_mult_driver #(
  parameter int FIRST_MATRIX_HEIGHT = 5,
  parameter int BOTH_MATRIX_W_H     = 5,
  parameter int SECOND_MATRIX_WIDTH = 5,
  parameter int DATA_WIDTH          = 8,
  parameter int TIMEOUT             = 1024
) (
  input  logic                                                 clk,
  input  logic                                                 i_rst,
  input  logic [DATA_WIDTH-1:0]                                i_data,
  input  logic                                                 i_valid,
  output logic                                                 o_in_ready,
  output logic [FIRST_MATRIX_HEIGHT*BOTH_MATRIX_W_H*DATA_WIDTH-1:0] o_matrix_1,
  output logic [BOTH_MATRIX_W_H*SECOND_MATRIX_WIDTH*DATA_WIDTH-1:0] o_matrix_2,
  output logic                                                 o_calc,
  input  logic                                                 i_mult_ready,
  input  logic [FIRST_MATRIX_HEIGHT*SECOND_MATRIX_WIDTH*DATA_WIDTH-1:0] i_result,
  output logic [DATA_WIDTH-1:0]                                o_data,
  output logic                                                 o_valid,
  output logic                                                 o_last,
  input  logic                                                 i_out_ready,
  output logic                                                 o_busy,
  output logic                                                 o_error
);
  localparam int DW  = DATA_WIDTH;
  localparam int A_N = FIRST_MATRIX_HEIGHT * BOTH_MATRIX_W_H;
  localparam int B_N = BOTH_MATRIX_W_H * SECOND_MATRIX_WIDTH;
  localparam int R_N = FIRST_MATRIX_HEIGHT * SECOND_MATRIX_WIDTH;
  localparam int AW  = A_N > 1 ? $clog2(A_N) : 1;
  localparam int BW  = B_N > 1 ? $clog2(B_N) : 1;
  localparam int RW  = R_N > 1 ? $clog2(R_N) : 1;
  localparam int TW  = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  localparam logic [AW-1:0] A_LAST = AW'(A_N - 1);
  localparam logic [BW-1:0] B_LAST = BW'(B_N - 1);
  localparam logic [RW-1:0] R_LAST = RW'(R_N - 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
  localparam logic [2:0] LOAD_A = 3'd0;
  localparam logic [2:0] LOAD_B = 3'd1;
  localparam logic [2:0] CALC   = 3'd2;
  localparam logic [2:0] WAIT   = 3'd3;
  localparam logic [2:0] DRAIN  = 3'd4;

  logic [2:0]          state;
  logic [AW-1:0]       a_idx;
  logic [BW-1:0]       b_idx;
  logic [RW-1:0]       out_idx;
  logic [TW-1:0]       timer;
  logic                ready_prev;
  logic [R_N*DW-1:0]   result;
  logic                take;
  logic                rise;
  logic                give;

  assign o_in_ready = state == LOAD_A || state == LOAD_B;
  assign o_calc     = state == CALC;
  assign o_valid    = state == DRAIN;
  assign o_data     = result[out_idx*DW +: DW];
  assign o_last     = o_valid && out_idx == R_LAST;
  assign o_busy     = !(state == LOAD_A && a_idx == '0);
  assign take       = i_valid && o_in_ready;
  assign rise       = i_mult_ready && !ready_prev;
  assign give       = o_valid && i_out_ready;

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state      <= LOAD_A;
      a_idx      <= '0;
      b_idx      <= '0;
      out_idx    <= '0;
      timer      <= '0;
      ready_prev <= 1'b1;
      o_matrix_1 <= '0;
      o_matrix_2 <= '0;
      result     <= '0;
      o_error    <= 1'b0;
    end else begin
      ready_prev <= i_mult_ready;
      o_error    <= 1'b0;
      case (state)
        LOAD_A: if (take) begin
          o_matrix_1[a_idx*DW +: DW] <= i_data;
          a_idx <= a_idx == A_LAST ? '0 : a_idx + 1'b1;
          if (a_idx == A_LAST) state <= LOAD_B;
        end
        LOAD_B: if (take) begin
          o_matrix_2[b_idx*DW +: DW] <= i_data;
          b_idx <= b_idx == B_LAST ? '0 : b_idx + 1'b1;
          if (b_idx == B_LAST) state <= CALC;
        end
        CALC: begin
          timer <= '0;
          state <= WAIT;
        end
        WAIT: if (rise) begin
          result  <= i_result;
          out_idx <= '0;
          state   <= DRAIN;
        end else if (timer == T_LAST) begin
          o_error    <= 1'b1;
          o_matrix_1 <= '0;
          o_matrix_2 <= '0;
          state      <= LOAD_A;
        end else begin
          timer <= timer + 1'b1;
        end
        DRAIN: if (give) begin
          out_idx <= out_idx + 1'b1;
          if (o_last) state <= LOAD_A;
        end
        default: state <= LOAD_A;
      endcase
    end
  end
endmodule

// File: doc/matrix_mult_driver.md
Name: matrix_mult_driver

Overview:
- Initiator for the matrix multiplier core: collects operand elements from a serial valid/ready stream and packs them into the flattened operand buses.
- Pulses the multiplier's calc input, then waits for the multiplier's ready.
- Captures the flattened result bus and streams it out one element per handshake.
- Sits between a serial host/DMA interface and the parallel multiplier.

Parameters:
- FIRST_MATRIX_HEIGHT, 5, rows of A (M)
- BOTH_MATRIX_W_H, 5, cols of A = rows of B (K)
- SECOND_MATRIX_WIDTH, 5, cols of B (N)
- DATA_WIDTH, 8, element width
- TIMEOUT, 1024, max cycles spent in WAIT before abort (>=2)

Ports:
- clk  input  1  clock
- i_rst  input  1  synchronous active-high reset
- i_data  input  DATA_WIDTH  operand element in
- i_valid  input  1  i_data valid
- o_in_ready  output  1  driver accepts i_data
- o_matrix_1  output  M*K*DATA_WIDTH  packed A to multiplier
- o_matrix_2  output  K*N*DATA_WIDTH  packed B to multiplier
- o_calc  output  1  one-cycle start pulse to multiplier
- i_mult_ready  input  1  multiplier result-ready
- i_result  input  M*N*DATA_WIDTH  multiplier result bus
- o_data  output  DATA_WIDTH  result element out
- o_valid  output  1  o_data valid
- o_last  output  1  final result element (with o_valid)
- i_out_ready  input  1  downstream accepts o_data
- o_busy  output  1  high in every state except LOAD_A with index 0
- o_error  output  1  one-cycle pulse on WAIT timeout

Behaviour:
- Clocking/reset: one clock domain, synchronous active-high reset i_rst.
- Reset values:
  - state=LOAD_A, all counters 0.
  - o_matrix_1, o_matrix_2, captured result all 0.
  - o_calc, o_valid, o_last, o_error, o_busy all 0.
  - o_in_ready=1.
  - ready_prev=1.
  - Reset mid-operation aborts immediately; partially loaded data is cleared.
- Packing:
  - A(r,c) occupies o_matrix_1[(r*K+c)*DATA_WIDTH +: DATA_WIDTH].
  - B(r,c) occupies o_matrix_2[(r*N+c)*DATA_WIDTH +: DATA_WIDTH].
  - Result(r,c) is i_result[(r*N+c)*DATA_WIDTH +: DATA_WIDTH].
- Input order: row-major, all A elements first, then all B elements.
- Transfer rule: a transfer occurs when i_valid && o_in_ready at clk.
- LOAD_A:
  - o_in_ready=1.
  - Each transfer writes slot idx and increments idx.
  - On transfer with idx==M*K-1: idx<=0, go to LOAD_B.
- LOAD_B:
  - Same as LOAD_A for K*N elements.
  - On the last transfer: o_in_ready<=0, go to CALC.
- CALC:
  - o_calc=1 for exactly this one cycle; go to WAIT; timer<=0.
  - Operand buses are held stable from CALC until return to LOAD_A.
- WAIT:
  - o_in_ready=0; timer increments each cycle.
  - ready_prev is registered i_mult_ready, sampled every cycle in all states.
  - Capture condition: i_mult_ready && !ready_prev. This is rising-edge detection, so a stale high ready from a previous run never triggers capture.
  - On capture: latch i_result into the internal result register, out_idx<=0, go to DRAIN.
  - On timer==TIMEOUT-1 with no rising edge: pulse o_error 1 cycle, go to LOAD_A, clear operands.
  - A rise seen on the same cycle as expiry takes priority over timeout.
- DRAIN:
  - o_valid=1; o_data=result element out_idx; o_last=(out_idx==M*N-1).
  - Output only advances on i_out_ready. o_data/o_last are stable while o_valid && !i_out_ready.
  - On handshake with o_last: o_valid<=0 next cycle, go to LOAD_A, o_in_ready<=1, operand buses retained (not cleared).
  - Input is not accepted during DRAIN.
- Throughput/latency:
  - Load: one element per cycle at full rate.
  - Last B transfer to o_calc: 1 cycle.
  - Capture edge to first o_valid: 1 cycle.
- Counter widths: $clog2 of the respective element count, minimum 1 bit.
- i_valid asserted in CALC/WAIT/DRAIN is ignored; data is held by upstream.

Test Plan:
- Nominal run (M=K=N=2, DW=8): stream 1,2,3,4,5,6,7,8 back-to-back with bench multiplier model (ready rises 3 cycles after calc). Required:
  - o_matrix_1=0x04030201, o_matrix_2=0x08070605.
  - o_calc single pulse 1 cycle after the 8th transfer.
  - Output stream 19,22,43,50 with o_last only on 50.
- Input gaps: i_valid toggling 1/0 during load -> same packed buses; o_calc fires exactly once after the 8th accepted element.
- Output backpressure: i_out_ready low for 3 cycles mid-drain -> o_data holds value (e.g. 22) stable; no element lost or duplicated.
- Stale ready: i_mult_ready held high from reset through CALC, never falling -> no capture; o_error pulses at cycle TIMEOUT of WAIT (set TIMEOUT=16); returns to LOAD_A with o_in_ready=1.
- Reset mid-WAIT: assert i_rst for 1 cycle -> next cycle all outputs at reset values; a subsequent full run produces correct results.
- Back-to-back runs: second operand set 2,0,0,2,1,1,1,1 loaded immediately after o_last -> output 2,2,2,2.
